fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage directly upstream of the 32-entry program memory. It owns the program counter and drives the memory address. It latches the returned instruction word into an instruction register presented to the decode/execute stage with a valid/stall handshake. It also handles branch redirects with a one-slot flush, halt requests, end-of-memory stop or wrap, and a saturating fetch counter.

## Interface
Parameters:
- ADDR_W, 5, program memory address width (32 words)
- INS_W, 6, instruction word width ({opcode, 2-bit register select})
- START_ADDR, 0, PC value after reset and on restart
- NOP_WORD, 6'h00, word loaded into `ir` on reset and flush; must equal the ISA NOP encoding
- STOP_AT_END, 1, 1: halt after fetching the last address; 0: wrap PC to 0

Ports:
- clk, input, 1, single clock, rising-edge
- rst_n, input, 1, asynchronous active-low reset
- run, input, 1, start/restart pulse; sampled in IDLE and HALT
- halt_req, input, 1, stop fetching; sampled in RUN
- stall, input, 1, consumer not taking `ir` this cycle
- branch_en, input, 1, redirect PC this cycle
- branch_addr, input, ADDR_W, redirect target
- ins_in, input, INS_W, program memory read data (combinational read of `addr`)
- addr, output, ADDR_W, program memory address; equals `pc`
- pc, output, ADDR_W, current program counter
- ir, output, INS_W, instruction register
- ir_valid, output, 1, `ir` holds an instruction for the consumer
- halted, output, 1, high in HALT
- fetch_cnt, output, 8, accepted fetches since reset/restart, saturating at 255

## Operation
- States: IDLE, RUN, HALT. `halted` = (state == HALT).
- IDLE: no fetch. `run` goes to RUN. Other inputs are ignored.
- RUN: per-edge priority is halt_req > branch_en > stall > fetch.
  - halt_req: go to HALT. PC, `ir` and `ir_valid` hold. No fetch.
  - branch_en: `pc <= branch_addr`, `ir <= NOP_WORD`, `ir_valid <= 0`. No fetch, and `fetch_cnt` does not change. The branch is taken even when `stall` = 1.
  - stall (no halt or branch): all registers hold.
  - fetch: `ir <= ins_in`, `ir_valid <= 1`, `fetch_cnt <= min(fetch_cnt+1, 255)`.
    - If `pc` < 2^ADDR_W−1: `pc <= pc+1`.
    - If `pc` = 2^ADDR_W−1 and STOP_AT_END=1: `pc` holds and the state goes to HALT after this fetch.
    - If `pc` = 2^ADDR_W−1 and STOP_AT_END=0: `pc <= 0` and the state stays RUN.
- HALT: no fetch. `pc` holds.
  - `ir_valid` stays 1 until the first edge with `stall` = 0, then clears; the last instruction drains once.
  - `run` restarts: `pc <= START_ADDR`, `ir <= NOP_WORD`, `ir_valid <= 0`, `fetch_cnt <= 0`, state goes to RUN.
- `run` asserted while in RUN is ignored.

## Timing
- Reset (asynchronous, rst_n = 0): state = IDLE, `pc`/`addr` = START_ADDR, `ir` = NOP_WORD, `ir_valid` = 0, `halted` = 0, `fetch_cnt` = 0.
- Outputs are registered, except `addr`, which is a wire copy of `pc`.
- Fetch latency: `addr` = N in cycle k gives `ir` = Mem[N] and `ir_valid` = 1 after edge k. Throughput is one instruction per cycle when `stall` = 0.
- First fetch: the edge that samples `run` in IDLE only changes the state. The first fetch happens on the next edge, so `ir_valid` rises 2 edges after `run`.
- Branch: after the branch edge there is one bubble cycle (`ir_valid` = 0, `addr` = target). The target instruction is valid after the following edge.
- Stall is combinational-free. It is sampled at the edge and has no input-to-output path.
- Reset asserted mid-RUN clears all state immediately, with no clock required.
- `fetch_cnt` saturates at 255 and never wraps.

## Test plan
- Reset with rst_n = 0 mid-RUN: all outputs take their reset values before the next clk edge. After release, state is IDLE and `addr` = 0.
- `run` pulse with memory words 0..4 = A..E, stall low: `ir` = A,B,C,D,E on consecutive cycles, `ir_valid` = 1 from the 2nd edge after `run`, `fetch_cnt` = 5.
- Stall held 3 cycles while `ir` = C: `ir`, `pc` and `fetch_cnt` are frozen with `ir_valid` = 1. After release, D follows next.
- branch_en with branch_addr = 20 and stall = 1 at the same edge: next cycle has `ir` = NOP_WORD, `ir_valid` = 0, `addr` = 20. Then `ir` = Mem[20]. `fetch_cnt` is unchanged by the branch edge.
- End of memory:
  - STOP_AT_END=1, run from 28: Mem[28..31] fetched, then `halted` = 1 with `pc` = 31. `ir_valid` clears after one non-stall edge. A later `run` restarts at 0 with `fetch_cnt` = 0.
  - STOP_AT_END=0: after Mem[31] the next fetch is Mem[0], with no halt.
- halt_req together with branch_en in RUN: the state goes to HALT and `pc` is unchanged; the branch is ignored. 300 fetches with STOP_AT_END=0 give `fetch_cnt` = 255.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if
// Bundles the fetch stage's control, program-memory and decode-side signals.
//   master : fetch_unit side.
//            Inputs:  run, halt_req, stall, branch_en, branch_addr, ins_in.
//            Outputs: addr, pc, ir, ir_valid, halted, fetch_cnt.
//   slave  : environment side (control logic, program memory, decode stage).
//            Directions are the mirror image of master.
interface fetch_if #(
    parameter int ADDR_W = 5,
    parameter int INS_W  = 6
);
    logic              run;
    logic              halt_req;
    logic              stall;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_addr;
    logic [INS_W-1:0]  ins_in;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ir;
    logic              ir_valid;
    logic              halted;
    logic [7:0]        fetch_cnt;

    modport master (
        input  run, halt_req, stall, branch_en, branch_addr, ins_in,
        output addr, pc, ir, ir_valid, halted, fetch_cnt
    );

    modport slave (
        output run, halt_req, stall, branch_en, branch_addr, ins_in,
        input  addr, pc, ir, ir_valid, halted, fetch_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage in front of a 2^ADDR_W-word program memory.
// It owns the program counter and drives the memory address. It latches the
// returned word into an instruction register that the decode stage takes
// through a valid/stall handshake.
// It also handles branch redirects (one bubble), halt requests, stop or wrap
// at the end of memory, and a saturating count of accepted fetches.
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   bus (fetch_if.master):
//     run               : start/restart pulse, seen in IDLE and HALT
//     halt_req          : stop fetching, seen in RUN
//     stall             : consumer is not taking ir this cycle
//     branch_en/addr    : redirect the PC
//     ins_in            : memory read data for the current addr
//     addr, pc          : program counter (addr is a wire copy of pc)
//     ir, ir_valid      : instruction register and its valid flag
//     halted            : high while in HALT
//     fetch_cnt         : accepted fetches since reset/restart, saturates at 255
module fetch_unit #(
    parameter int                ADDR_W      = 5,
    parameter int                INS_W       = 6,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0,
    parameter logic [INS_W-1:0]  NOP_WORD    = '0,
    parameter bit                STOP_AT_END = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [INS_W-1:0]  ir_q, ir_nxt;
    logic              valid_q, valid_nxt;
    logic [7:0]        cnt_q, cnt_nxt;

    // Every architectural register is updated here from the next-state
    // values. Reset forces the fetch stage back to an idle, empty pipeline
    // with the PC parked at the start address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= START_ADDR;
            ir_q    <= NOP_WORD;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            ir_q    <= ir_nxt;
            valid_q <= valid_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state and next-register logic. Every register holds by default.
    // In RUN the priority is halt_req, then branch, then stall, then fetch.
    // A branch squashes the word sitting in ir, so the consumer sees one
    // bubble. The halt request wins even over a branch, so the PC stays
    // where it was when the halt took effect.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        valid_nxt = valid_q;
        cnt_nxt   = cnt_q;
        unique case (state)
            IDLE: begin
                if (bus.run) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.halt_req) begin
                    state_nxt = HALT;
                end else if (bus.branch_en) begin
                    pc_nxt    = bus.branch_addr;
                    ir_nxt    = NOP_WORD;
                    valid_nxt = 1'b0;
                end else if (!bus.stall) begin
                    ir_nxt    = bus.ins_in;
                    valid_nxt = 1'b1;
                    if (cnt_q != 8'hFF) begin
                        cnt_nxt = cnt_q + 8'd1;
                    end
                    if (pc_q != LAST_ADDR) begin
                        pc_nxt = pc_q + ADDR_W'(1);
                    end else if (STOP_AT_END) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = '0;
                    end
                end
            end
            HALT: begin
                // The last fetched word stays valid until the consumer
                // takes it once (the first non-stall edge).
                if (bus.run) begin
                    state_nxt = RUN;
                    pc_nxt    = START_ADDR;
                    ir_nxt    = NOP_WORD;
                    valid_nxt = 1'b0;
                    cnt_nxt   = 8'd0;
                end else if (!bus.stall) begin
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.addr      = pc_q;
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = valid_q;
    assign bus.halted    = (state == HALT);
    assign bus.fetch_cnt = cnt_q;

endmodule
